// File: rtl/picam_loader_pkg.sv
// picam_loader_pkg: shared types and pin-index constants for the PICAM input loader.
// Rev 1.0
`default_nettype none

package picam_loader_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HALF = 1'b1
  } loader_state_t;

  typedef struct packed {
    logic       cmd;
    logic [7:0] data;
  } loader_entry_t;

  localparam int NIB_LSB    = 0;
  localparam int STROBE_BIT = 4;
  localparam int CMD_BIT    = 5;

endpackage

`default_nettype wire

// File: rtl/picam_loader_fifo.sv
// picam_loader_fifo: DEPTH-entry FIFO of tagged bytes, head exposed from registered storage.
// Rev 1.0
`default_nettype none

module picam_loader_fifo
  import picam_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  loader_entry_t           push_entry,
  input  logic                    pop,
  output loader_entry_t           head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  loader_entry_t   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop frees the slot this same edge, so a full FIFO can still accept.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign head = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

`default_nettype wire

// File: rtl/picam_input_loader.sv
// picam_input_loader: synchronises the 6 user pins, pairs strobed nibbles into tagged bytes, queues them.
// Rev 1.0
`default_nettype none

module picam_input_loader
  import picam_loader_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] in_in_,
  output logic [7:0] out_data,
  output logic       out_is_cmd,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow,
  output logic       timeout_err,
  output logic       half_pending
);

  localparam int              TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int              CW         = $clog2(DEPTH) + 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);

  logic [5:0]     s1;
  logic [5:0]     s2;
  logic           s2_prev;
  logic           strobe_edge;

  loader_state_t  state, state_next;
  logic [3:0]     hi, hi_next;
  logic           cmd, cmd_next;
  logic [TW-1:0]  timer, timer_next;
  logic           push;
  logic           expire;

  loader_entry_t  push_entry;
  loader_entry_t  head;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic           drop;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      s2_prev <= 1'b0;
    end else begin
      s1      <= in_in_;
      s2      <= s1;
      s2_prev <= s2[STROBE_BIT];
    end
  end

  assign strobe_edge = s2[STROBE_BIT] & ~s2_prev;

  always_comb begin
    state_next = state;
    hi_next    = hi;
    cmd_next   = cmd;
    timer_next = timer;
    push       = 1'b0;
    expire     = 1'b0;
    unique case (state)
      IDLE: begin
        if (strobe_edge) begin
          hi_next    = s2[NIB_LSB +: 4];
          cmd_next   = s2[CMD_BIT];
          timer_next = '0;
          state_next = HALF;
        end
      end
      HALF: begin
        // Edge is tested first so it wins on the expiry cycle.
        if (strobe_edge) begin
          push       = 1'b1;
          state_next = IDLE;
        end else if (timer == TIMER_LAST) begin
          expire     = 1'b1;
          hi_next    = '0;
          state_next = IDLE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      hi          <= '0;
      cmd         <= 1'b0;
      timer       <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_next;
      hi    <= hi_next;
      cmd   <= cmd_next;
      timer <= timer_next;
      if (drop)   overflow    <= 1'b1;
      if (expire) timeout_err <= 1'b1;
    end
  end

  assign push_entry.cmd  = cmd;
  assign push_entry.data = {hi, s2[NIB_LSB +: 4]};

  picam_loader_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (out_ready),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // Full implies non-empty, so out_ready alone tells whether a slot frees up.
  assign drop = push & fifo_full & ~out_ready;

  assign out_valid    = ~fifo_empty;
  assign out_data     = fifo_empty ? 8'h00 : head.data;
  assign out_is_cmd   = fifo_empty ? 1'b0  : head.cmd;
  assign half_pending = (state == HALF);

  count_in_range : assert property (@(posedge clock) disable iff (reset) fifo_count <= CW'(DEPTH));

endmodule

`default_nettype wire

// File: tb/tb_picam_input_loader.sv
// tb_picam_input_loader: vector table plus hand-written corner sequences, scoreboard-checked.
// Rev 1.0
`default_nettype none

module tb_picam_input_loader;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 100;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] in_in_;
  logic [7:0] out_data;
  logic       out_is_cmd;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;
  logic       timeout_err;
  logic       half_pending;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] sb[$];

  typedef struct {
    string      name;
    logic [3:0] hi;
    logic [3:0] lo;
    logic       cmd_hi;
    logic       cmd_lo;
    logic [7:0] exp_data;
    logic       exp_cmd;
  } vec_t;

  vec_t vecs[5];

  always #5 clock = ~clock;

  picam_input_loader #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_in_       (in_in_),
    .out_data     (out_data),
    .out_is_cmd   (out_is_cmd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overflow     (overflow),
    .timeout_err  (timeout_err),
    .half_pending (half_pending)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},   out_valid,    0);
    check({tag, "_data"},    out_data,     0);
    check({tag, "_is_cmd"},  out_is_cmd,   0);
    check({tag, "_ovf"},     overflow,     0);
    check({tag, "_tmo"},     timeout_err,  0);
    check({tag, "_pending"}, half_pending, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  // Strobe pin rises one cycle after the nibble is set, stays high two cycles.
  task automatic strobe_nibble(input logic [3:0] nib, input logic cmd);
    in_in_ = {cmd, 1'b0, nib};
    tick();
    in_in_[4] = 1'b1;
    tick();
    tick();
    in_in_[4] = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_byte(input logic [3:0] hi, input logic [3:0] lo, input logic ch,
                           input logic cl, input logic [7:0] exp_data, input logic exp_cmd,
                           input logic dropped);
    strobe_nibble(hi, ch);
    if (!dropped) sb.push_back({exp_cmd, exp_data});
    strobe_nibble(lo, cl);
  endtask

  task automatic pop_check(input string name);
    logic [8:0] exp;
    int waited;
    waited = 0;
    @(negedge clock);
    while (!out_valid && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (!out_valid) begin
      check({name, "_valid_timeout"}, out_valid, 1);
      return;
    end
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected byte 0x%0h, scoreboard empty", name, {out_is_cmd, out_data});
      return;
    end
    exp = sb.pop_front();
    check(name, {out_is_cmd, out_data}, exp);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [8:0] exp_head;

    vecs[0] = '{"cmd_tag",      4'h3, 4'hC, 1'b1, 1'b0, 8'h3C, 1'b1};
    vecs[1] = '{"cmd_lo_ignored", 4'hF, 4'h0, 1'b0, 1'b1, 8'hF0, 1'b0};
    vecs[2] = '{"zero_cmd",     4'h0, 4'h0, 1'b1, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{"data_5a",      4'h5, 4'hA, 1'b0, 1'b0, 8'h5A, 1'b0};
    vecs[4] = '{"cmd_e7",       4'hE, 4'h7, 1'b1, 1'b0, 8'hE7, 1'b1};

    in_in_    = '0;
    out_ready = 1'b0;
    reset     = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Basic byte with exact output latency and hold while not ready.
    strobe_nibble(4'hA, 1'b0);
    check("basic_half_pending", half_pending, 1);
    sb.push_back({1'b0, 8'hA5});
    in_in_ = {2'b00, 4'h5};
    tick();
    in_in_[4] = 1'b1;
    tick();
    check("lat_edge_k", out_valid, 0);
    tick();
    check("lat_edge_k1", out_valid, 0);
    tick();
    check("lat_edge_k2", out_valid, 1);
    in_in_[4] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("basic_hold", {out_is_cmd, out_data}, 9'h0A5);
    end
    check("basic_not_pending", half_pending, 0);
    pop_check("basic_byte");
    check("basic_drained", out_valid, 0);

    for (int i = 0; i < 5; i++) begin
      send_byte(vecs[i].hi, vecs[i].lo, vecs[i].cmd_hi, vecs[i].cmd_lo,
                vecs[i].exp_data, vecs[i].exp_cmd, 1'b0);
      pop_check(vecs[i].name);
    end

    // Half-byte abandoned long enough to expire.
    do_reset();
    strobe_nibble(4'h7, 1'b0);
    check("tmo_pending", half_pending, 1);
    repeat (TIMEOUT + 5) tick();
    check("tmo_pending_fell", half_pending, 0);
    check("tmo_flag", timeout_err, 1);
    check("tmo_no_push", out_valid, 0);
    send_byte(4'h1, 4'h2, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0);
    pop_check("tmo_recover");
    check("tmo_sticky", timeout_err, 1);

    // Second edge lands exactly on the expiry cycle: the byte completes.
    do_reset();
    in_in_ = {2'b00, 4'h6};
    tick();
    in_in_[4] = 1'b1;
    tick();
    tick();
    in_in_[4] = 1'b0;
    repeat (TIMEOUT - 2) tick();
    in_in_[3:0] = 4'h9;
    in_in_[4]   = 1'b1;
    sb.push_back({1'b0, 8'h69});
    tick();
    tick();
    in_in_[4] = 1'b0;
    tick();
    tick();
    check("expiry_edge_no_tmo", timeout_err, 0);
    pop_check("expiry_edge_byte");

    // One cycle later the half-byte has already expired; the edge starts a new byte.
    do_reset();
    in_in_ = {2'b00, 4'h6};
    tick();
    in_in_[4] = 1'b1;
    tick();
    tick();
    in_in_[4] = 1'b0;
    repeat (TIMEOUT - 1) tick();
    in_in_[3:0] = 4'h9;
    in_in_[4]   = 1'b1;
    tick();
    tick();
    in_in_[4] = 1'b0;
    tick();
    tick();
    check("late_edge_tmo", timeout_err, 1);
    check("late_edge_new_half", half_pending, 1);
    check("late_edge_no_push", out_valid, 0);

    // Overflow: fifth byte dropped while not ready.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      send_byte(4'h0, 4'(i), 1'b0, 1'b0, 8'(i), 1'b0, (i == 5));
    end
    check("ovf_flag", overflow, 1);
    check("ovf_valid", out_valid, 1);
    for (int i = 0; i < DEPTH; i++) pop_check("ovf_order");
    check("ovf_drained", out_valid, 0);
    check("ovf_sticky", overflow, 1);

    // Full FIFO with a pop on the push edge: both happen, no overflow.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      send_byte(4'h0, 4'(i), 1'b0, 1'b0, 8'(i), 1'b0, 1'b0);
    end
    strobe_nibble(4'h0, 1'b0);
    in_in_ = {2'b00, 4'h5};
    tick();
    in_in_[4] = 1'b1;
    tick();
    tick();
    in_in_[4] = 1'b0;
    exp_head = sb.pop_front();
    check("simul_head", {out_is_cmd, out_data}, exp_head);
    sb.push_back(9'h005);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("simul_no_ovf", overflow, 0);
    for (int i = 0; i < DEPTH; i++) pop_check("simul_order");
    check("simul_drained", out_valid, 0);

    // Reset with queued bytes and a held high nibble.
    do_reset();
    send_byte(4'hB, 4'h1, 1'b0, 1'b0, 8'hB1, 1'b0, 1'b0);
    send_byte(4'hC, 4'h2, 1'b1, 1'b0, 8'hC2, 1'b1, 1'b0);
    strobe_nibble(4'h9, 1'b0);
    check("mid_pending", half_pending, 1);
    check("mid_valid", out_valid, 1);
    reset = 1'b1;
    tick();
    check_all_zero("mid_reset");
    reset = 1'b0;
    sb.delete();
    tick();
    send_byte(4'h4, 4'h4, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0);
    pop_check("after_reset");
    check("after_reset_drained", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
